// File: rtl/d_flip_flop.sv
// Parameterised D-type register chain with true and complemented outputs.
// Optional clock enable port compiled in when DFLIPFLOP_CE_EN is defined.
module d_flip_flop #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
`ifdef DFLIPFLOP_CE_EN
  input  logic             en,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic load;

`ifdef DFLIPFLOP_CE_EN
  assign load = en;
`else
  assign load = 1'b1;
`endif

  logic [WIDTH-1:0] stage_q [STAGES];

  // Reset flushes every stage and outranks the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= RESET_VALUE;
      end
    end else if (load) begin
      stage_q[0] <= d;
      for (int unsigned k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q    = stage_q[STAGES-1];
  // Combinational inversion keeps qbar exactly in step with q.
  assign qbar = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: three parameterisations driven in parallel,
// checked against a history-of-samples reference model.
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst_s = 1'b0;
  logic       en_s = 1'b1;
  logic [3:0] d_s = 4'h0;

  logic [3:0] q_a, qbar_a, q_b, qbar_b, q_c, qbar_c;

  always #5 clk = ~clk;

`ifdef DFLIPFLOP_CE_EN
  localparam bit HasEn = 1'b1;
`else
  localparam bit HasEn = 1'b0;
`endif

  d_flip_flop #(.WIDTH(4), .STAGES(1), .RESET_VALUE(4'h0)) dut_a (
    .clk(clk), .rst(rst_s), .d(d_s),
`ifdef DFLIPFLOP_CE_EN
    .en(en_s),
`endif
    .q(q_a), .qbar(qbar_a)
  );

  d_flip_flop #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'h0)) dut_b (
    .clk(clk), .rst(rst_s), .d(d_s),
`ifdef DFLIPFLOP_CE_EN
    .en(en_s),
`endif
    .q(q_b), .qbar(qbar_b)
  );

  d_flip_flop #(.WIDTH(4), .STAGES(2), .RESET_VALUE(4'h6)) dut_c (
    .clk(clk), .rst(rst_s), .d(d_s),
`ifdef DFLIPFLOP_CE_EN
    .en(en_s),
`endif
    .q(q_c), .qbar(qbar_c)
  );

  typedef struct packed {
    logic [3:0] qa;
    logic [3:0] qb;
    logic [3:0] qc;
  } exp_t;

  exp_t       exp_q [$];
  // Values captured on loading edges since the most recent reset edge.
  logic [3:0] hist [$];
  int         n_vec = 0;
  int         n_err = 0;

  // q shows the sample taken s loading edges ago, or the reset value if
  // fewer than s samples have been taken since reset.
  function automatic logic [3:0] ref_q(int unsigned s, logic [3:0] rv);
    if (hist.size() >= s) return hist[hist.size() - s];
    return rv;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, want);
    end
  endtask

  // Monitor: outputs are presented every cycle after an edge has been issued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q_s1",     q_a,    e.qa);
        check("qbar_s1",  qbar_a, ~e.qa);
        check("q_s3",     q_b,    e.qb);
        check("qbar_s3",  qbar_b, ~e.qb);
        check("q_s2rv6",  q_c,    e.qc);
        check("qbar_s2rv6", qbar_c, ~e.qc);
      end
    end
  end

  // One clock of stimulus; glitch pulses rst and d between edges.
  task automatic step(input logic [3:0] d, input logic rst, input logic en, input logic glitch);
    logic eff_en;
    exp_t e;
    @(negedge clk);
    d_s   = d;
    rst_s = rst;
    en_s  = en;
    @(posedge clk);
    eff_en = HasEn ? en : 1'b1;
    if (rst) begin
      hist.delete();
    end else if (eff_en) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    e.qa = ref_q(1, 4'h0);
    e.qb = ref_q(3, 4'h0);
    e.qc = ref_q(2, 4'h6);
    exp_q.push_back(e);
    if (glitch && !rst) begin
      #1 rst_s = 1'b1;
      d_s = ~d;
      #1 rst_s = 1'b0;
      d_s = d;
    end
  endtask

  initial begin
    // Reset with d=A, then capture and mid-cycle glitch checks.
    step(4'hA, 1'b1, 1'b1, 1'b0);
    step(4'h1, 1'b0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b1, 1'b1);
    step(4'h1, 1'b0, 1'b1, 1'b1);
    step(4'h0, 1'b0, 1'b1, 1'b0);
    // Reset mid-stream for the 3-stage chain.
    step(4'h1, 1'b0, 1'b1, 1'b0);
    step(4'h2, 1'b0, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b1, 1'b0);
    step(4'h4, 1'b0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b1, 1'b0);
    // Hold with enable low, then release; reset beats enable low.
    step(4'h5, 1'b0, 1'b1, 1'b0);
    step(4'h5, 1'b0, 1'b1, 1'b0);
    step(4'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h9, 1'b0, 1'b0, 1'b0);
    step(4'h9, 1'b0, 1'b1, 1'b0);
    step(4'hC, 1'b1, 1'b0, 1'b0);
    step(4'hD, 1'b0, 1'b0, 1'b0);
    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
